// File: rtl/tlb_op_ctrl.sv
// TLB maintenance initiator: runs TLBSRCH/RD/WR/FILL/INVTLB against the TLB ports and
// returns results through a valid/ready response. Define TLB_FILL_LFSR_EN for an LFSR FILL index.
module tlb_op_ctrl #(
    parameter int unsigned TLBNUM     = 16,
    parameter int unsigned TLBNUMSIZE = 4,
    parameter int unsigned PHYTRAN_W  = 26
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [2:0]            op_code,
    input  logic [2:0]            inv_op,
    input  logic [9:0]            inv_asid,
    input  logic [18:0]           inv_va,
    input  logic [TLBNUMSIZE-1:0] csr_index,
    input  logic [5:0]            csr_ps,
    input  logic                  csr_ne,
    input  logic [18:0]           csr_vppn,
    input  logic [9:0]            csr_asid,
    input  logic                  csr_g,
    input  logic [PHYTRAN_W-1:0]  csr_elo0,
    input  logic [PHYTRAN_W-1:0]  csr_elo1,
    input  logic [5:0]            csr_ecode,
    output logic [18:0]           s_vppn,
    output logic [9:0]            s_asid,
    output logic                  s_req,
    input  logic [TLBNUMSIZE-1:0] s_index,
    input  logic                  s_ne,
    output logic [TLBNUMSIZE-1:0] r_index,
    input  logic [5:0]            r_ps,
    input  logic [9:0]            r_asid,
    input  logic [18:0]           r_vppn,
    input  logic                  r_g,
    input  logic                  r_ne,
    input  logic [PHYTRAN_W-1:0]  r_phytran0,
    input  logic [PHYTRAN_W-1:0]  r_phytran1,
    output logic                  we,
    output logic [TLBNUMSIZE-1:0] w_index,
    output logic [5:0]            w_ps,
    output logic                  w_ne,
    output logic [9:0]            w_asid,
    output logic [18:0]           w_vppn,
    output logic                  w_g,
    output logic [PHYTRAN_W-1:0]  w_phytran0,
    output logic [PHYTRAN_W-1:0]  w_phytran1,
    output logic                  fe,
    output logic [2:0]            f_op,
    output logic [9:0]            f_asid,
    output logic [18:0]           f_va,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [2:0]            resp_op,
    output logic                  resp_ne,
    output logic [TLBNUMSIZE-1:0] resp_index,
    output logic [5:0]            resp_ps,
    output logic [9:0]            resp_asid,
    output logic [18:0]           resp_vppn,
    output logic                  resp_g,
    output logic [PHYTRAN_W-1:0]  resp_phytran0,
    output logic [PHYTRAN_W-1:0]  resp_phytran1,
    output logic                  resp_ine
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
    typedef enum logic [2:0] {OP_SRCH = 3'd0, OP_RD = 3'd1, OP_WR = 3'd2,
                              OP_FILL = 3'd3, OP_INV = 3'd4} op_e;

    typedef struct packed {
        logic [2:0]            op;
        logic [2:0]            inv_op;
        logic [9:0]            inv_asid;
        logic [18:0]           inv_va;
        logic [TLBNUMSIZE-1:0] index;
        logic [5:0]            ps;
        logic                  ne;
        logic [18:0]           vppn;
        logic [9:0]            asid;
        logic                  g;
        logic [PHYTRAN_W-1:0]  elo0;
        logic [PHYTRAN_W-1:0]  elo1;
        logic [5:0]            ecode;
        logic [TLBNUMSIZE-1:0] fill_idx;
    } req_t;

    typedef struct packed {
        logic [2:0]            op;
        logic                  ne;
        logic [TLBNUMSIZE-1:0] index;
        logic [5:0]            ps;
        logic [9:0]            asid;
        logic [18:0]           vppn;
        logic                  g;
        logic [PHYTRAN_W-1:0]  pt0;
        logic [PHYTRAN_W-1:0]  pt1;
        logic                  ine;
    } resp_t;

    state_e state_q, state_d;
    req_t   req_q, req_d;
    resp_t  resp_q, resp_d;
    logic [TLBNUMSIZE-1:0] fill_idx;

`ifdef TLB_FILL_LFSR_EN
    logic [7:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) lfsr_q <= 8'h01;
        else         lfsr_q <= lfsr_d;
    end

    assign fill_idx = lfsr_q[TLBNUMSIZE-1:0];
`else
    logic [TLBNUMSIZE-1:0] fill_idx_q, fill_idx_d;

    always_comb begin
        fill_idx_d = (fill_idx_q == TLBNUMSIZE'(TLBNUM - 1)) ? '0 : fill_idx_q + 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) fill_idx_q <= '0;
        else         fill_idx_q <= fill_idx_d;
    end

    assign fill_idx = fill_idx_q;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            req_q   <= '0;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            resp_q  <= resp_d;
        end
    end

    // Port strobes are decoded from state_q, so an async reset in EXEC drops we/fe at once.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        resp_d     = resp_q;
        op_ready   = 1'b0;
        s_req      = 1'b0;
        s_vppn     = '0;
        s_asid     = '0;
        r_index    = '0;
        we         = 1'b0;
        w_index    = '0;
        w_ps       = '0;
        w_ne       = 1'b0;
        w_asid     = '0;
        w_vppn     = '0;
        w_g        = 1'b0;
        w_phytran0 = '0;
        w_phytran1 = '0;
        fe         = 1'b0;
        f_op       = '0;
        f_asid     = '0;
        f_va       = '0;

        case (state_q)
            IDLE: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    req_d.op       = op_code;
                    req_d.inv_op   = inv_op;
                    req_d.inv_asid = inv_asid;
                    req_d.inv_va   = inv_va;
                    req_d.index    = csr_index;
                    req_d.ps       = csr_ps;
                    req_d.ne       = csr_ne;
                    req_d.vppn     = csr_vppn;
                    req_d.asid     = csr_asid;
                    req_d.g        = csr_g;
                    req_d.elo0     = csr_elo0;
                    req_d.elo1     = csr_elo1;
                    req_d.ecode    = csr_ecode;
                    req_d.fill_idx = fill_idx;
                    state_d        = EXEC;
                end
            end
            EXEC: begin
                state_d     = RESP;
                resp_d      = '0;
                resp_d.op   = req_q.op;
                case (req_q.op)
                    OP_SRCH: begin
                        s_req        = 1'b1;
                        s_vppn       = req_q.vppn;
                        s_asid       = req_q.asid;
                        resp_d.ne    = s_ne;
                        resp_d.index = s_index;
                    end
                    OP_RD: begin
                        r_index     = req_q.index;
                        resp_d.ne   = r_ne;
                        resp_d.ps   = r_ps;
                        resp_d.asid = r_asid;
                        resp_d.vppn = r_vppn;
                        resp_d.g    = r_g;
                        resp_d.pt0  = r_phytran0;
                        resp_d.pt1  = r_phytran1;
                    end
                    OP_WR, OP_FILL: begin
                        we         = 1'b1;
                        w_index    = (req_q.op == OP_FILL) ? req_q.fill_idx : req_q.index;
                        // Ecode 0x3F marks a TLB refill, whose entries are always written valid.
                        w_ne       = (req_q.ecode == 6'h3F) ? 1'b0 : req_q.ne;
                        w_ps       = req_q.ps;
                        w_asid     = req_q.asid;
                        w_vppn     = req_q.vppn;
                        w_g        = req_q.g;
                        w_phytran0 = req_q.elo0;
                        w_phytran1 = req_q.elo1;
                    end
                    OP_INV: begin
                        if (req_q.inv_op <= 3'd6) begin
                            fe     = 1'b1;
                            f_op   = req_q.inv_op;
                            f_asid = req_q.inv_asid;
                            f_va   = req_q.inv_va;
                        end else begin
                            resp_d.ine = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            RESP: begin
                if (resp_ready) begin
                    state_d    = IDLE;
                    resp_d.ine = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign resp_valid    = (state_q == RESP);
    assign resp_op       = resp_q.op;
    assign resp_ne       = resp_q.ne;
    assign resp_index    = resp_q.index;
    assign resp_ps       = resp_q.ps;
    assign resp_asid     = resp_q.asid;
    assign resp_vppn     = resp_q.vppn;
    assign resp_g        = resp_q.g;
    assign resp_phytran0 = resp_q.pt0;
    assign resp_phytran1 = resp_q.pt1;
    assign resp_ine      = resp_q.ine;

endmodule
